// File: rtl/fft_frame_writer_if.sv
// Avalon-ST style FFT source stream: framing strobes plus one complex sample per beat.
// The FFT core drives the master side and the frame writer consumes the slave side.
interface fft_frame_writer_if #(
    parameter int DATAIN_WIDTH = 29
);
    logic                    sop;
    logic                    eop;
    logic                    valid;
    logic [DATAIN_WIDTH-1:0] datain_re;
    logic [DATAIN_WIDTH-1:0] datain_im;

    modport master (output sop, eop, valid, datain_re, datain_im);
    modport slave  (input  sop, eop, valid, datain_re, datain_im);
endinterface

// File: rtl/fft_frame_writer.sv
// Captures each FFT output frame into one half of a ping-pong result RAM.
// Adds length/overflow/restart error tracking, a completion strobe and a frame counter.
module fft_frame_writer #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATAIN_WIDTH = 29,
    parameter int HALF_WIDTH   = 32,
    parameter bit SIGN_EXTEND  = 1'b0,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    enable,
    input  logic [ADDR_WIDTH:0]     frame_len,
    input  logic                    clr_err,
    fft_frame_writer_if.slave       st,
    output logic [ADDR_WIDTH:0]     addr,
    output logic [2*HALF_WIDTH-1:0] dataout,
    output logic                    wren,
    output logic                    done,
    output logic                    last_bank,
    output logic [ADDR_WIDTH:0]     last_count,
    output logic [CNT_WIDTH-1:0]    frame_cnt,
    output logic                    err_len,
    output logic                    err_ovf,
    output logic                    err_sop
);

    typedef enum logic [0:0] {IDLE, CAPT} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                  state_q, state_d;
    logic                    bank_q, bank_d;
    logic [ADDR_WIDTH:0]     idx_q, idx_d;
    logic                    ovf_q, ovf_d;
    logic [ADDR_WIDTH:0]     addr_q, addr_d;
    logic [2*HALF_WIDTH-1:0] dataout_q, dataout_d;
    logic                    wren_q, wren_d;
    logic                    done_q, done_d;
    logic                    last_bank_q, last_bank_d;
    logic [ADDR_WIDTH:0]     last_count_q, last_count_d;
    logic [CNT_WIDTH-1:0]    frame_cnt_q, frame_cnt_d;
    logic                    err_len_q, err_len_d;
    logic                    err_ovf_q, err_ovf_d;
    logic                    err_sop_q, err_sop_d;

    logic [DATAIN_WIDTH-1:0] re_in, im_in;
    logic [HALF_WIDTH-1:0]   re_ext, im_ext;

    assign re_in = st.datain_re;
    assign im_in = st.datain_im;

    if (SIGN_EXTEND) begin : g_sext
        assign re_ext = HALF_WIDTH'($signed(re_in));
        assign im_ext = HALF_WIDTH'($signed(im_in));
    end else begin : g_zext
        assign re_ext = HALF_WIDTH'(re_in);
        assign im_ext = HALF_WIDTH'(im_in);
    end

    logic                accept;
    logic                restart;
    logic                wr_en;
    logic [ADDR_WIDTH:0] wr_idx;
    logic [ADDR_WIDTH:0] cnt_new;
    logic                ovf_new;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        bank_d       = bank_q;
        idx_d        = idx_q;
        ovf_d        = ovf_q;
        addr_d       = addr_q;
        dataout_d    = dataout_q;
        wren_d       = 1'b0;
        done_d       = 1'b0;
        last_bank_d  = last_bank_q;
        last_count_d = last_count_q;
        frame_cnt_d  = frame_cnt_q;
        err_len_d    = clr_err ? 1'b0 : err_len_q;
        err_ovf_d    = clr_err ? 1'b0 : err_ovf_q;
        err_sop_d    = clr_err ? 1'b0 : err_sop_q;
        accept       = 1'b0;
        restart      = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = '0;
        cnt_new      = idx_q;
        ovf_new      = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (st.valid && st.sop && enable) begin
                    accept  = 1'b1;
                    restart = 1'b1;
                end
            end
            CAPT: begin
                if (st.valid) begin
                    accept = 1'b1;
                    if (st.sop) begin
                        restart   = 1'b1;
                        err_sop_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (accept) begin
            if (restart) begin
                wr_en   = 1'b1;
                wr_idx  = '0;
                cnt_new = (ADDR_WIDTH+1)'(1);
                ovf_new = 1'b0;
            end else if (idx_q < DEPTH) begin
                wr_en   = 1'b1;
                wr_idx  = idx_q;
                cnt_new = idx_q + (ADDR_WIDTH+1)'(1);
            end else begin
                // Bank full: the beat is dropped, the count stays saturated at DEPTH.
                ovf_new   = 1'b1;
                err_ovf_d = 1'b1;
            end

            state_d = CAPT;
            idx_d   = cnt_new;
            ovf_d   = ovf_new;

            if (wr_en) begin
                wren_d    = 1'b1;
                addr_d    = {bank_q, wr_idx[ADDR_WIDTH-1:0]};
                dataout_d = {re_ext, im_ext};
            end

            if (st.eop) begin
                done_d       = 1'b1;
                last_bank_d  = bank_q;
                last_count_d = cnt_new;
                frame_cnt_d  = frame_cnt_q + CNT_WIDTH'(1);
                // An overflowed frame always mismatches, even though its count saturates.
                if (cnt_new != frame_len || ovf_new) err_len_d = 1'b1;
                bank_d  = ~bank_q;
                state_d = IDLE;
                idx_d   = '0;
                ovf_d   = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            bank_q       <= 1'b0;
            idx_q        <= '0;
            ovf_q        <= 1'b0;
            addr_q       <= '0;
            dataout_q    <= '0;
            wren_q       <= 1'b0;
            done_q       <= 1'b0;
            last_bank_q  <= 1'b0;
            last_count_q <= '0;
            frame_cnt_q  <= '0;
            err_len_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_sop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            idx_q        <= idx_d;
            ovf_q        <= ovf_d;
            addr_q       <= addr_d;
            dataout_q    <= dataout_d;
            wren_q       <= wren_d;
            done_q       <= done_d;
            last_bank_q  <= last_bank_d;
            last_count_q <= last_count_d;
            frame_cnt_q  <= frame_cnt_d;
            err_len_q    <= err_len_d;
            err_ovf_q    <= err_ovf_d;
            err_sop_q    <= err_sop_d;
        end
    end

    assign addr       = addr_q;
    assign dataout    = dataout_q;
    assign wren       = wren_q;
    assign done       = done_q;
    assign last_bank  = last_bank_q;
    assign last_count = last_count_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_len    = err_len_q;
    assign err_ovf    = err_ovf_q;
    assign err_sop    = err_sop_q;

endmodule

// File: tb/tb_fft_frame_writer.sv
// Directed bench for fft_frame_writer: a monitor logs RAM writes and done strobes,
// and each scenario task compares the logs and status outputs with hand-derived values.
module tb_fft_frame_writer;

    localparam int AW = 10;
    localparam int DW = 29;
    localparam int HW = 32;
    localparam int CW = 16;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            enable = 1'b0;
    logic [AW:0]     frame_len = '0;
    logic            clr_err = 1'b0;
    logic [AW:0]     addr;
    logic [2*HW-1:0] dataout;
    logic            wren, done, last_bank, err_len, err_ovf, err_sop;
    logic [AW:0]     last_count;
    logic [CW-1:0]   frame_cnt;

    fft_frame_writer_if #(.DATAIN_WIDTH(DW)) st_if ();

    fft_frame_writer #(
        .ADDR_WIDTH(AW), .DATAIN_WIDTH(DW), .HALF_WIDTH(HW), .SIGN_EXTEND(1'b1), .CNT_WIDTH(CW)
    ) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .frame_len(frame_len), .clr_err(clr_err),
        .st(st_if), .addr(addr), .dataout(dataout), .wren(wren), .done(done),
        .last_bank(last_bank), .last_count(last_count), .frame_cnt(frame_cnt),
        .err_len(err_len), .err_ovf(err_ovf), .err_sop(err_sop)
    );

    always #5 CLK = ~CLK;

    typedef struct { int cyc; logic [AW:0] addr; logic [2*HW-1:0] data; } wr_t;
    typedef struct { int cyc; logic lb; logic [AW:0] lc; logic [CW-1:0] fc; } dn_t;

    wr_t wr_log[$];
    dn_t done_log[$];
    int  acc_cyc[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    always @(posedge CLK) begin
        cyc = cyc + 1;
        #2;
        if (wren === 1'b1) wr_log.push_back('{cyc, addr, dataout});
        if (done === 1'b1) done_log.push_back('{cyc, last_bank, last_count, frame_cnt});
    end

    function automatic logic [63:0] exp_word(input int i, input bit neg, input int c);
        logic [31:0] hi, lo;
        hi = i;
        lo = neg ? -i : c;
        return {hi, lo};
    endfunction

    task automatic clear_logs();
        wr_log.delete();
        done_log.delete();
        acc_cyc.delete();
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input int re, input int im);
        st_if.valid     = v;
        st_if.sop       = s;
        st_if.eop       = e;
        st_if.datain_re = DW'(re);
        st_if.datain_im = DW'(im);
        @(posedge CLK);
        #1;
        if (v) acc_cyc.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic send_frame(input int n, input bit neg, input int c, input bit drop_en);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, i == 0, i == n - 1, i, neg ? -i : c);
            if (drop_en && i == 0) enable = 1'b0;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        st_if.valid = 1'b0; st_if.sop = 1'b0; st_if.eop = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(1);
        clear_logs();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        st_if.valid = 1'b0; st_if.sop = 1'b0; st_if.eop = 1'b0;
        st_if.datain_re = '0; st_if.datain_im = '0;
        #3;
        checks++;
        if ({wren, done} !== 2'b00) begin
            failures++; $display("FAIL reset_strobes got=%b required=00", {wren, done});
        end
        checks++;
        if ({addr, dataout} !== '0) begin
            failures++; $display("FAIL reset_bus got=%h/%h required=0", addr, dataout);
        end
        checks++;
        if ({last_bank, last_count, frame_cnt} !== '0) begin
            failures++; $display("FAIL reset_status got=%b/%0d/%0d required=0", last_bank, last_count, frame_cnt);
        end
        checks++;
        if ({err_len, err_ovf, err_sop} !== 3'b000) begin
            failures++; $display("FAIL reset_errs got=%b required=000", {err_len, err_ovf, err_sop});
        end
        do_reset();
    endtask

    task automatic test_full_frame();
        int bad = 0;
        do_reset();
        enable = 1'b1; frame_len = 11'd1024;
        send_frame(1024, 1'b1, 0, 1'b0);
        idle(3);
        checks++;
        if (wr_log.size() !== 1024) begin
            failures++; $display("FAIL full_wcount got=%0d required=1024", wr_log.size());
        end
        foreach (wr_log[k]) if (wr_log[k].addr !== 11'(k) || wr_log[k].data !== exp_word(k, 1'b1, 0)) bad++;
        checks++;
        if (bad !== 0) begin
            failures++; $display("FAIL full_words bad=%0d required=0", bad);
        end
        if (wr_log.size() >= 1024 && done_log.size() >= 1) begin
            checks++;
            if (wr_log[5].data !== 64'h00000005_FFFFFFFB) begin
                failures++; $display("FAIL full_word5 got=%h required=00000005fffffffb", wr_log[5].data);
            end
            checks++;
            if (done_log[0].cyc !== wr_log[1023].cyc) begin
                failures++; $display("FAIL full_done_cycle got=%0d required=%0d", done_log[0].cyc, wr_log[1023].cyc);
            end
        end
        checks++;
        if (done_log.size() !== 1) begin
            failures++; $display("FAIL full_done_count got=%0d required=1", done_log.size());
        end
        checks++;
        if ({last_bank, last_count, frame_cnt} !== {1'b0, 11'd1024, 16'd1}) begin
            failures++; $display("FAIL full_status got=%b/%0d/%0d required=0/1024/1", last_bank, last_count, frame_cnt);
        end
        checks++;
        if ({err_len, err_ovf, err_sop} !== 3'b000) begin
            failures++; $display("FAIL full_errs got=%b required=000", {err_len, err_ovf, err_sop});
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        do_reset();
        enable = 1'b1; frame_len = 11'd1024;
        send_frame(1024, 1'b0, 1, 1'b0);
        send_frame(1024, 1'b0, 2, 1'b0);
        idle(3);
        checks++;
        if (wr_log.size() !== 2048) begin
            failures++; $display("FAIL b2b_wcount got=%0d required=2048", wr_log.size());
        end
        foreach (wr_log[k])
            if (wr_log[k].addr !== 11'(k) ||
                wr_log[k].data !== (k < 1024 ? exp_word(k, 1'b0, 1) : exp_word(k - 1024, 1'b0, 2))) bad++;
        checks++;
        if (bad !== 0) begin
            failures++; $display("FAIL b2b_words bad=%0d required=0", bad);
        end
        checks++;
        if (done_log.size() !== 2) begin
            failures++; $display("FAIL b2b_done_count got=%0d required=2", done_log.size());
        end else begin
            checks++;
            if ({done_log[0].lb, done_log[1].lb} !== 2'b01) begin
                failures++; $display("FAIL b2b_done_banks got=%b%b required=01", done_log[0].lb, done_log[1].lb);
            end
        end
        checks++;
        if ({last_bank, frame_cnt} !== {1'b1, 16'd2}) begin
            failures++; $display("FAIL b2b_status got=%b/%0d required=1/2", last_bank, frame_cnt);
        end
    endtask

    task automatic test_gaps();
        int bad = 0;
        do_reset();
        enable = 1'b1; frame_len = 11'd16;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i == 0, i == 15, i, 3);
            // Gap cycles carry sop/eop with valid low; they must be ignored.
            if (i % 2 == 0 && i < 15) repeat (2) drive(1'b0, 1'b1, 1'b1, 99, 99);
        end
        idle(3);
        checks++;
        if (wr_log.size() !== 16 || acc_cyc.size() !== 16) begin
            failures++; $display("FAIL gaps_wcount got=%0d required=16", wr_log.size());
        end else begin
            foreach (wr_log[k])
                if (wr_log[k].addr !== 11'(k) || wr_log[k].data !== exp_word(k, 1'b0, 3) ||
                    wr_log[k].cyc !== acc_cyc[k]) bad++;
            checks++;
            if (bad !== 0) begin
                failures++; $display("FAIL gaps_words bad=%0d required=0", bad);
            end
        end
        checks++;
        if ({done_log.size() == 1, last_count, err_len} !== {1'b1, 11'd16, 1'b0}) begin
            failures++; $display("FAIL gaps_status done=%0d count=%0d err_len=%b required=1/16/0",
                                 done_log.size(), last_count, err_len);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        enable = 1'b1; frame_len = 11'd1024;
        send_frame(1030, 1'b0, 0, 1'b0);
        idle(3);
        checks++;
        if (wr_log.size() !== 1024) begin
            failures++; $display("FAIL ovf_wcount got=%0d required=1024", wr_log.size());
        end
        checks++;
        if ({done_log.size() == 1, last_count} !== {1'b1, 11'd1024}) begin
            failures++; $display("FAIL ovf_commit done=%0d count=%0d required=1/1024", done_log.size(), last_count);
        end
        checks++;
        if ({err_len, err_ovf, err_sop} !== 3'b110) begin
            failures++; $display("FAIL ovf_errs got=%b required=110", {err_len, err_ovf, err_sop});
        end
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        checks++;
        if ({err_len, err_ovf} !== 2'b00) begin
            failures++; $display("FAIL ovf_clear got=%b required=00", {err_len, err_ovf});
        end
    endtask

    task automatic test_mid_sop();
        do_reset();
        enable = 1'b1; frame_len = 11'd1024;
        for (int i = 0; i < 100; i++) drive(1'b1, i == 0, 1'b0, i, 5);
        send_frame(1024, 1'b0, 6, 1'b0);
        idle(3);
        checks++;
        if (wr_log.size() !== 1124) begin
            failures++; $display("FAIL sop_wcount got=%0d required=1124", wr_log.size());
        end else begin
            checks++;
            if ({wr_log[100].addr, wr_log[100].data, wr_log[1123].addr} !== {11'd0, exp_word(0, 1'b0, 6), 11'd1023}) begin
                failures++; $display("FAIL sop_rewrite got=%0d/%h/%0d required=0/%h/1023",
                                     wr_log[100].addr, wr_log[100].data, wr_log[1123].addr, exp_word(0, 1'b0, 6));
            end
        end
        checks++;
        if ({done_log.size() == 1, last_bank, last_count, frame_cnt} !== {1'b1, 1'b0, 11'd1024, 16'd1}) begin
            failures++; $display("FAIL sop_commit done=%0d bank=%b count=%0d frames=%0d required=1/0/1024/1",
                                 done_log.size(), last_bank, last_count, frame_cnt);
        end
        checks++;
        if ({err_len, err_ovf, err_sop} !== 3'b001) begin
            failures++; $display("FAIL sop_errs got=%b required=001", {err_len, err_ovf, err_sop});
        end
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        checks++;
        if (err_sop !== 1'b0) begin
            failures++; $display("FAIL sop_clear got=%b required=0", err_sop);
        end
        drive(1'b1, 1'b1, 1'b0, 0, 0);
        clr_err = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 0, 0);
        clr_err = 1'b0;
        checks++;
        if (err_sop !== 1'b1) begin
            failures++; $display("FAIL sop_error_wins got=%b required=1", err_sop);
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        enable = 1'b1; frame_len = 11'd1024;
        for (int i = 0; i < 500; i++) drive(1'b1, i == 0, 1'b0, i, 0);
        RST = 1'b1;
        #2;
        checks++;
        if ({addr, dataout, wren, done, last_bank, last_count, frame_cnt, err_len, err_ovf, err_sop} !== '0) begin
            failures++; $display("FAIL abort_outputs wren=%b addr=%0d data=%h frames=%0d required=all zero",
                                 wren, addr, dataout, frame_cnt);
        end
        checks++;
        if (done_log.size() !== 0) begin
            failures++; $display("FAIL abort_no_done got=%0d required=0", done_log.size());
        end
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        st_if.valid = 1'b0;
        idle(1);
        clear_logs();

        frame_len = 11'd16;
        send_frame(16, 1'b0, 7, 1'b0);
        idle(3);
        checks++;
        if (wr_log.size() !== 16) begin
            failures++; $display("FAIL fresh_wcount got=%0d required=16", wr_log.size());
        end else begin
            checks++;
            if ({wr_log[0].addr, wr_log[15].addr} !== {11'd0, 11'd15}) begin
                failures++; $display("FAIL fresh_addr got=%0d..%0d required=0..15", wr_log[0].addr, wr_log[15].addr);
            end
        end
        checks++;
        if ({done_log.size() == 1, last_bank, frame_cnt} !== {1'b1, 1'b0, 16'd1}) begin
            failures++; $display("FAIL fresh_commit done=%0d bank=%b frames=%0d required=1/0/1",
                                 done_log.size(), last_bank, frame_cnt);
        end

        clear_logs();
        enable = 1'b0;
        send_frame(8, 1'b0, 0, 1'b0);
        idle(3);
        checks++;
        if ({wr_log.size() == 0, done_log.size() == 0, frame_cnt} !== {1'b1, 1'b1, 16'd1}) begin
            failures++; $display("FAIL disabled_frame writes=%0d done=%0d frames=%0d required=0/0/1",
                                 wr_log.size(), done_log.size(), frame_cnt);
        end

        clear_logs();
        enable = 1'b1;
        send_frame(16, 1'b0, 8, 1'b1);
        idle(3);
        enable = 1'b1;
        checks++;
        if (wr_log.size() !== 16) begin
            failures++; $display("FAIL en_drop_wcount got=%0d required=16", wr_log.size());
        end else begin
            checks++;
            if ({wr_log[0].addr, wr_log[15].addr} !== {11'd1024, 11'd1039}) begin
                failures++; $display("FAIL en_drop_addr got=%0d..%0d required=1024..1039", wr_log[0].addr, wr_log[15].addr);
            end
        end
        checks++;
        if ({last_bank, frame_cnt} !== {1'b1, 16'd2}) begin
            failures++; $display("FAIL en_drop_status got=%b/%0d required=1/2", last_bank, frame_cnt);
        end

        clear_logs();
        frame_len = 11'd1;
        drive(1'b1, 1'b1, 1'b1, 42, 43);
        idle(3);
        checks++;
        if (wr_log.size() !== 1) begin
            failures++; $display("FAIL one_beat_wcount got=%0d required=1", wr_log.size());
        end else begin
            checks++;
            if ({wr_log[0].addr, wr_log[0].data} !== {11'd0, exp_word(42, 1'b0, 43)}) begin
                failures++; $display("FAIL one_beat_word got=%0d/%h required=0/%h", wr_log[0].addr, wr_log[0].data,
                                     exp_word(42, 1'b0, 43));
            end
        end
        checks++;
        if ({done_log.size() == 1, last_bank, last_count, frame_cnt, err_len} !== {1'b1, 1'b0, 11'd1, 16'd3, 1'b0}) begin
            failures++; $display("FAIL one_beat_commit done=%0d bank=%b count=%0d frames=%0d err_len=%b required=1/0/1/3/0",
                                 done_log.size(), last_bank, last_count, frame_cnt, err_len);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_gaps();
        test_overflow();
        test_mid_sop();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
